modmul_barrett_ctrl: RTL and testbench

Sequencer that computes one 54-bit Barrett modular product r = a·b mod q by time-sharing a single external pipelined 56×56 multiplier across three passes: product, quotient estimate, quotient×modulus. It sits between the modular-arithmetic request source and the shared DSP multiplier. It uses valid/ready handshakes on both its input and its output. It adds the final conditional subtractions and an error flag for verification.

---
 rtl/modmul_barrett_ctrl.sv | 150 +++++++++++++++
 tb/tb_modmul_barrett_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/modmul_barrett_ctrl.sv
// Barrett modular multiplier sequencer: r = a*b mod q using one shared pipelined
// external multiplier for the product, quotient-estimate and quotient*modulus passes.
module modmul_barrett_ctrl #(
  parameter int MUL_SIZE = 56,
  parameter int RADIX    = 54,
  parameter int MUL_LAT  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [MUL_SIZE-1:0]   i_in_a,
  input  logic [MUL_SIZE-1:0]   i_in_b,
  input  logic [MUL_SIZE-1:0]   i_cfg_q,
  input  logic [MUL_SIZE-1:0]   i_cfg_mu,
  output logic                  o_mul_en,
  output logic [MUL_SIZE-1:0]   o_mul_a,
  output logic [MUL_SIZE-1:0]   o_mul_b,
  input  logic [2*MUL_SIZE-1:0] i_mul_p,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [MUL_SIZE-1:0]   o_out_r,
  output logic                  o_out_err
);

  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL1, S_MUL2, S_MUL3, S_CORR1, S_CORR2, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [MUL_SIZE-1:0] r_q;
  logic [MUL_SIZE-1:0] r_mu;
  logic [MUL_SIZE-1:0] r_p_lo;
  logic [MUL_SIZE-1:0] r_r;
  logic [MUL_SIZE-1:0] r_mul_a;
  logic [MUL_SIZE-1:0] r_mul_b;
  logic [MUL_SIZE-1:0] r_out_r;
  logic                r_out_err;
  logic                w_in_mul;
  logic                w_cnt_done;
  logic [MUL_SIZE-1:0] w_r_corr;

  assign w_in_mul   = (r_state == S_MUL1) || (r_state == S_MUL2) || (r_state == S_MUL3);
  assign w_cnt_done = w_in_mul && (r_cnt == CW'(MUL_LAT));
  assign w_r_corr   = (r_r >= r_q) ? (r_r - r_q) : r_r;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_mul_en    = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_state_nxt = S_MUL1;
      end
      S_MUL1: begin
        o_mul_en = 1'b1;
        if (w_cnt_done) w_state_nxt = S_MUL2;
      end
      S_MUL2: begin
        o_mul_en = 1'b1;
        if (w_cnt_done) w_state_nxt = S_MUL3;
      end
      S_MUL3: begin
        o_mul_en = 1'b1;
        if (w_cnt_done) w_state_nxt = S_CORR1;
      end
      S_CORR1: w_state_nxt = S_CORR2;
      S_CORR2: w_state_nxt = S_DONE;
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next-pass operands come straight from i_mul_p so each pass starts on the sampling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_q       <= '0;
      r_mu      <= '0;
      r_p_lo    <= '0;
      r_r       <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_out_r   <= '0;
      r_out_err <= 1'b0;
    end else begin
      r_cnt <= (w_in_mul && !w_cnt_done) ? (r_cnt + CW'(1)) : '0;
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_q     <= i_cfg_q;
            r_mu    <= i_cfg_mu;
            r_mul_a <= i_in_a;
            r_mul_b <= i_in_b;
          end
        end
        S_MUL1: begin
          if (w_cnt_done) begin
            r_p_lo  <= i_mul_p[MUL_SIZE-1:0];
            r_mul_a <= MUL_SIZE'(i_mul_p >> (RADIX - 1));
            r_mul_b <= r_mu;
          end
        end
        S_MUL2: begin
          if (w_cnt_done) begin
            r_mul_a <= MUL_SIZE'(i_mul_p >> (RADIX + 1));
            r_mul_b <= r_q;
          end
        end
        S_MUL3: begin
          if (w_cnt_done) begin
            r_r     <= r_p_lo - i_mul_p[MUL_SIZE-1:0];
            r_mul_a <= '0;
            r_mul_b <= '0;
          end
        end
        S_CORR1: r_r <= w_r_corr;
        S_CORR2: begin
          r_r       <= w_r_corr;
          r_out_r   <= w_r_corr;
          r_out_err <= (w_r_corr >= r_q);
        end
        default: ;
      endcase
    end
  end

  assign o_mul_a   = r_mul_a;
  assign o_mul_b   = r_mul_b;
  assign o_out_r   = r_out_r;
  assign o_out_err = r_out_err;

endmodule

// File: tb/tb_modmul_barrett_ctrl.sv
// Directed bench for modmul_barrett_ctrl at MUL_LAT = 2, 1 and 4, each instance with its
// own pipelined multiplier model; results are checked against a mod-q reference queue.
module tb_modmul_barrett_ctrl;

  localparam int MS = 56;
  localparam int PW = 2 * MS;
  localparam logic [MS-1:0] Q  = MS'((64'd1 << 54) - 64'd33);
  localparam logic [MS-1:0] MU = MS'((64'd1 << 54) + 64'd33);

  logic          clk;
  logic          rst_n;
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic [MS-1:0] in_a, in_b, cfg_q, cfg_mu;
  logic          mul_en    [3];
  logic [MS-1:0] mul_a     [3];
  logic [MS-1:0] mul_b     [3];
  logic [PW-1:0] mul_p     [3];
  logic          out_valid [3];
  logic          out_ready;
  logic [MS-1:0] out_r     [3];
  logic          out_err   [3];

  int unsigned cyc;
  int n_chk;
  int n_fail;
  logic [MS:0] exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [PW-1:0] pipe [L];
    always @(posedge clk) begin
      if (mul_en[g]) begin
        pipe[0] <= PW'(mul_a[g]) * PW'(mul_b[g]);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign mul_p[g] = pipe[L-1];

    modmul_barrett_ctrl #(.MUL_SIZE(MS), .RADIX(54), .MUL_LAT(L)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid[g]),
      .o_in_ready  (in_ready[g]),
      .i_in_a      (in_a),
      .i_in_b      (in_b),
      .i_cfg_q     (cfg_q),
      .i_cfg_mu    (cfg_mu),
      .o_mul_en    (mul_en[g]),
      .o_mul_a     (mul_a[g]),
      .o_mul_b     (mul_b[g]),
      .i_mul_p     (mul_p[g]),
      .o_out_valid (out_valid[g]),
      .i_out_ready (out_ready),
      .o_out_r     (out_r[g]),
      .o_out_err   (out_err[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  function automatic logic [MS-1:0] ref_mod(input logic [MS-1:0] a, input logic [MS-1:0] b);
    logic [127:0] p;
    p = 128'(a) * 128'(b);
    return MS'(p % 128'(Q));
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s [lat=%0d]: observed %0h expected %0h", tag, lat_of(k), obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input int k);
    chk({tag, "_in_ready"}, k, 64'(in_ready[k]), 64'd1);
    chk({tag, "_mul_en"}, k, 64'(mul_en[k]), 64'd0);
    chk({tag, "_mul_a"}, k, 64'(mul_a[k]), 64'd0);
    chk({tag, "_mul_b"}, k, 64'(mul_b[k]), 64'd0);
    chk({tag, "_out_valid"}, k, 64'(out_valid[k]), 64'd0);
    chk({tag, "_out_r"}, k, 64'(out_r[k]), 64'd0);
    chk({tag, "_out_err"}, k, 64'(out_err[k]), 64'd0);
  endtask

  // Presents one request, scoreboards its expected result, returns the accepting cycle.
  task automatic issue(input int k, input logic [MS-1:0] a, input logic [MS-1:0] b,
                       output int unsigned acc);
    exp_q.push_back({1'b0, ref_mod(a, b)});
    @(negedge clk);
    in_a = a; in_b = b; cfg_q = Q; cfg_mu = MU;
    in_valid[k] = 1'b1;
    chk("in_ready_idle", k, 64'(in_ready[k]), 64'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid[k] = 1'b0;
    in_a = MS'({$urandom, $urandom});
    in_b = MS'({$urandom, $urandom});
    cfg_q = MS'({$urandom, $urandom});
    cfg_mu = MS'({$urandom, $urandom});
  endtask

  task automatic run(input int k, input logic [MS-1:0] a, input logic [MS-1:0] b, input int hold);
    int unsigned acc;
    int L;
    logic [127:0] q1, q3;
    logic [MS-1:0] ea, eb, r0;
    logic [MS:0] e;
    logic got;
    L = lat_of(k);
    q1 = (128'(a) * 128'(b)) >> 53;
    q3 = (q1 * 128'(MU)) >> 55;
    out_ready = (hold == 0);
    issue(k, a, b, acc);
    for (int p = 0; p < 3; p++) begin
      ea = (p == 0) ? a : ((p == 1) ? MS'(q1) : MS'(q3));
      eb = (p == 0) ? b : ((p == 1) ? MU : Q);
      for (int c = 0; c <= L; c++) begin
        @(negedge clk);
        chk("mul_en_on", k, 64'(mul_en[k]), 64'd1);
        chk("mul_a_op", k, 64'(mul_a[k]), 64'(ea));
        chk("mul_b_op", k, 64'(mul_b[k]), 64'(eb));
        if (c == 0) chk("in_ready_busy", k, 64'(in_ready[k]), 64'd0);
      end
    end
    @(negedge clk);
    chk("mul_en_off", k, 64'(mul_en[k]), 64'd0);
    chk("mul_a_zero", k, 64'(mul_a[k]), 64'd0);
    chk("early_valid", k, 64'(out_valid[k]), 64'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = out_valid[k];
    end
    chk("valid_seen", k, 64'(got), 64'd1);
    if (!got) return;
    chk("latency", k, 64'(cyc - acc + 1), 64'(3 * L + 6));
    chk("sb_nonempty", k, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("out_r", k, 64'(out_r[k]), 64'(e[MS-1:0]));
    chk("out_err", k, 64'(out_err[k]), 64'(e[MS]));
    r0 = e[MS-1:0];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_valid", k, 64'(out_valid[k]), 64'd1);
      chk("stall_out_r", k, 64'(out_r[k]), 64'(r0));
      chk("stall_in_ready", k, 64'(in_ready[k]), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_in_ready", k, 64'(in_ready[k]), 64'd1);
    chk("post_valid", k, 64'(out_valid[k]), 64'd0);
  endtask

  task automatic mid_reset(input int k);
    int unsigned acc;
    int L;
    L = lat_of(k);
    out_ready = 1'b1;
    issue(k, MS'(64'd9), MS'(64'd11), acc);
    repeat (L + 1) @(posedge clk);
    @(negedge clk);
    chk("in_mul2_en", k, 64'(mul_en[k]), 64'd1);
    chk("in_mul2_mu", k, 64'(mul_b[k]), 64'(MU));
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst", k);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3 * L + 10; i++) begin
      @(negedge clk);
      if (out_valid[k]) chk("ghost_valid", k, 64'(out_valid[k]), 64'd0);
    end
    chk("rst_idle", k, 64'(in_ready[k]), 64'd1);
    run(k, MS'(64'd5), MS'(64'd7), 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    out_ready = 1'b1;
    in_a = '0; in_b = '0; cfg_q = Q; cfg_mu = MU;
    for (int k = 0; k < 3; k++) in_valid[k] = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk_idle_outputs("reset", k);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run(k, MS'(64'd2), MS'(64'd3), 0);
      run(k, Q - MS'(1), Q - MS'(1), 0);
      run(k, MS'(64'd1 << 53), MS'(64'd4), 0);
      mid_reset(k);
      run(k, MS'(64'h0123_4567_89ab), MS'(64'h0fed_cba9_8765), 20);
      run(k, Q - MS'(1), MS'(64'd2), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
